// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address-field width helpers for the instruction cache.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL} icache_state_t;
  function automatic int wo_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int num_lines, input int words_per_line);
    return addr_w - 2 - $clog2(num_lines) - $clog2(words_per_line);
  endfunction
endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: unreset line storage with a combinational read port and a single write port.
module icache_data_array #(
  parameter int NUM_LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IW = 4,
  parameter int WO = 2
) (
  input  logic          clk_i,
  input  logic [IW-1:0] rd_idx,
  input  logic [WO-1:0] rd_woff,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [WO-1:0] wr_woff,
  input  logic [31:0]   wr_data
);
  logic [31:0] mem [NUM_LINES*WORDS_PER_LINE];
  assign rd_data = mem[{rd_idx, rd_woff}];
  always_ff @(posedge clk_i)
    if (we) mem[{wr_idx, wr_woff}] <= wr_data;
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped icache with same-cycle hits, burst line refill and fence.i invalidate.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_responder
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  input  logic              inv_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [31:0]       mem_rdata_i,
`ifdef ICACHE_STATS_EN
  input  logic              mem_rvalid_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`else
  input  logic              mem_rvalid_i
`endif
);
  localparam int WO = wo_w(WORDS_PER_LINE);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  icache_state_t state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [NUM_LINES];
  logic [WO-1:0] cnt_q, woff;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] atag;
  logic [31:0] rd_data;
  logic inv_pend_q, hit, start, beat, last, unused_ok;
  assign woff = addr_i[2 +: WO];
  assign idx = addr_i[2+WO +: IW];
  assign atag = addr_i[ADDR_W-1 -: TW];
  assign fidx = mem_addr_o[2+WO +: IW];
  assign unused_ok = ^addr_i[1:0];
  assign hit = state_q == IDLE && valid_q[idx] && tag_q[idx] == atag && !inv_i;
  assign start = state_q == IDLE && !hit && !inv_i;
  assign beat = state_q == FILL && mem_rvalid_i;
  assign last = beat && cnt_q == WO'(WORDS_PER_LINE - 1);
  assign valid_o = hit;
  assign data_o = hit ? rd_data : '0;
  icache_data_array #(
    .NUM_LINES(NUM_LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IW(IW),
    .WO(WO)
  ) u_data (
    .clk_i(clk_i),
    .rd_idx(idx),
    .rd_woff(woff),
    .rd_data(rd_data),
    .we(beat),
    .wr_idx(fidx),
    .wr_woff(cnt_q),
    .wr_data(mem_rdata_i)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? REQ : IDLE;
      REQ:     state_d = mem_gnt_i ? FILL : REQ;
      FILL:    state_d = last ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end
  // mem_addr_o doubles as the latched line base for the whole refill
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      mem_req_o <= 1'b0;
      mem_addr_o <= '0;
      cnt_q <= '0;
      inv_pend_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req_o <= 1'b1;
        mem_addr_o <= {addr_i[ADDR_W-1:2+WO], {(WO+2){1'b0}}};
      end else if (state_q == REQ && mem_gnt_i) mem_req_o <= 1'b0;
      cnt_q <= state_q == REQ ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
      inv_pend_q <= last ? 1'b0 : (inv_i && state_q != IDLE) ? 1'b1 : inv_pend_q;
      if ((state_q == IDLE && inv_i) || (last && (inv_pend_q || inv_i))) valid_q <= '0;
      else if (last) valid_q[fidx] <= 1'b1;
    end
  always_ff @(posedge clk_i)
    if (last) tag_q[fidx] <= mem_addr_o[ADDR_W-1 -: TW];
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && !(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (start && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scoreboard bench for icache_responder.
module tb_icache_responder;
  typedef struct packed {
    logic v;
    logic [31:0] d;
    logic r;
  } fetch_exp_t;
  logic clk_i = 1'b0, rst_n_i = 1'b0, inv_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] addr_i = '0, mem_rdata_i = '0, data_o, mem_addr_o;
  logic valid_o, mem_req_o, chk = 1'b0;
  fetch_exp_t fetch_q[$];
  logic [31:0] req_q[$];
  int errors = 0, checks = 0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
  icache_responder dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .addr_i(addr_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .inv_i(inv_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rdata_i(mem_rdata_i),
`ifdef ICACHE_STATS_EN
    .mem_rvalid_i(mem_rvalid_i),
    .hit_cnt_o(hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
`else
    .mem_rvalid_i(mem_rvalid_i)
`endif
  );
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (chk) begin
      checks++;
      if (fetch_q.size() == 0) begin
        errors++;
        $display("FAIL fetch: no expected entry queued");
      end else begin
        fetch_exp_t e;
        e = fetch_q.pop_front();
        if (valid_o !== e.v || data_o !== e.d || mem_req_o !== e.r) begin
          errors++;
          $display("FAIL fetch addr=%h: got v=%b d=%h req=%b, want v=%b d=%h req=%b",
                   addr_i, valid_o, data_o, mem_req_o, e.v, e.d, e.r);
        end
      end
    end
    if (mem_req_o && mem_gnt_i) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req: unexpected request addr=%h", mem_addr_o);
      end else begin
        logic [31:0] a;
        a = req_q.pop_front();
        if (mem_addr_o !== a) begin
          errors++;
          $display("FAIL req: got mem_addr_o=%h, want %h", mem_addr_o, a);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch_check(input logic [31:0] a, input logic v, input logic [31:0] d, input logic r);
    addr_i = a;
    fetch_q.push_back('{v: v, d: d, r: r});
    chk = 1'b1;
    step();
    chk = 1'b0;
  endtask

  task automatic grant(input logic [31:0] base);
    int n = 0;
    while (!mem_req_o && n < 20) begin
      step();
      n++;
    end
    if (!mem_req_o) begin
      errors++;
      checks++;
      $display("FAIL req-timeout: mem_req_o=0, want 1 for %h", base);
    end
    req_q.push_back(base);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
  endtask

  task automatic refill(input logic [31:0] base, input logic [31:0] b0, input int inv_at, input logic [31:0] br);
    grant(base);
    for (int i = 0; i < 4; i++) begin
      mem_rdata_i = b0 + i;
      mem_rvalid_i = 1'b1;
      inv_i = (i == inv_at);
      if (i == 2 && br != 0) addr_i = br;
      step();
      mem_rvalid_i = 1'b0;
      inv_i = 1'b0;
      if (i == 1) step();
    end
  endtask

  initial begin
    step();
    step();
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
      errors++;
      $display("FAIL stats-reset: got hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
    end
`endif
    rst_n_i = 1'b1;
    // cold miss, request held without grant, refill, first hit
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    fetch_check(32'h40, 1'b0, 32'h0, 1'b1);
    refill(32'h40, 32'hA0, -1, 0);
    fetch_check(32'h40, 1'b1, 32'hA0, 1'b0);
    fetch_check(32'h4C, 1'b1, 32'hA3, 1'b0);
    // conflict eviction on index 4
    fetch_check(32'h140, 1'b0, 32'h0, 1'b0);
    refill(32'h140, 32'hB0, -1, 0);
    fetch_check(32'h140, 1'b1, 32'hB0, 1'b0);
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    refill(32'h40, 32'hA0, -1, 0);
    fetch_check(32'h44, 1'b1, 32'hA1, 1'b0);
    // invalidate in IDLE, then mid-FILL
    inv_i = 1'b1;
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    inv_i = 1'b0;
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    refill(32'h40, 32'hC0, -1, 0);
    fetch_check(32'h48, 1'b1, 32'hC2, 1'b0);
    fetch_check(32'h140, 1'b0, 32'h0, 1'b0);
    refill(32'h140, 32'hD0, 1, 0);
    fetch_check(32'h140, 1'b0, 32'h0, 1'b0);
    refill(32'h140, 32'hD0, -1, 0);
    fetch_check(32'h14C, 1'b1, 32'hD3, 1'b0);
    // branch during refill
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    refill(32'h40, 32'hF0, -1, 32'h80);
    fetch_check(32'h80, 1'b0, 32'h0, 1'b0);
    refill(32'h80, 32'hE0, -1, 0);
    fetch_check(32'h80, 1'b1, 32'hE0, 1'b0);
    fetch_check(32'h40, 1'b1, 32'hF0, 1'b0);
    // reset mid-FILL with in-flight beats
    fetch_check(32'h240, 1'b0, 32'h0, 1'b0);
    grant(32'h240);
    for (int i = 0; i < 2; i++) begin
      mem_rdata_i = 32'h90 + i;
      mem_rvalid_i = 1'b1;
      step();
    end
    rst_n_i = 1'b0;
    mem_rdata_i = 32'h99;
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
      errors++;
      $display("FAIL stats-midreset: got hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
    end
`endif
    rst_n_i = 1'b1;
    fetch_check(32'h40, 1'b0, 32'h0, 1'b0);
    mem_rvalid_i = 1'b0;
    refill(32'h40, 32'h50, -1, 0);
    fetch_check(32'h40, 1'b1, 32'h50, 1'b0);
    fetch_check(32'h4C, 1'b1, 32'h53, 1'b0);
    step();
    checks++;
    if (fetch_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", fetch_q.size(), req_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
